// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package regfile_pkg;

  // Clear engine states: idle, sweeping registers, one-cycle completion state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_t;

  // Address width for a given register count; never narrower than one bit.
  function automatic int addr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue, cleared by writeback or clear sweep.
// Latency: set/clear take effect at the next rising edge; busy lookups are combinational.
// Backpressure: none; the caller gates set/clear while the clear engine owns the file.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int DEPTH      = 32,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int AW         = addr_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_set_en,
  input  logic [AW-1:0]              i_set_addr,
  input  logic                       i_clr_en,
  input  logic [AW-1:0]              i_clr_addr,
  input  logic                       i_wipe_en,
  input  logic [AW-1:0]              i_wipe_addr,
  input  logic [READ_PORTS*AW-1:0]   i_rd_addr,
  output logic [READ_PORTS-1:0]      o_busy
);

  // Register 0 can never be pending when it is hardwired to zero.
  localparam logic [DEPTH-1:0] ZERO_MASK = (ZERO_REG != 0) ? DEPTH'(1) : '0;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_set_oh;
  logic [DEPTH-1:0] w_clr_oh;
  logic [DEPTH-1:0] w_wipe_oh;
  logic [DEPTH-1:0] w_pend_next;

  // Next pending vector: writeback clears, a new issue to the same register wins, sweep clears last.
  always_comb begin
    w_set_oh    = i_set_en  ? (DEPTH'(1) << i_set_addr)  : '0;
    w_clr_oh    = i_clr_en  ? (DEPTH'(1) << i_clr_addr)  : '0;
    w_wipe_oh   = i_wipe_en ? (DEPTH'(1) << i_wipe_addr) : '0;
    w_pend_next = ((r_pend & ~w_clr_oh) | w_set_oh) & ~w_wipe_oh & ~ZERO_MASK;
  end

  // Pending bits state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  genvar p;
  generate
    for (p = 0; p < READ_PORTS; p++) begin : g_busy
      assign o_busy[p] = r_pend[i_rd_addr[p*AW +: AW]];
    end
  endgenerate

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with zero register, pending-write scoreboard and clear engine.
// Latency: reads combinational; writes/issues visible the cycle after the edge; clear takes DEPTH+1 cycles.
// Backpressure: writeEn/issueEn dropped while clearBusy=1; optional bypass via REGFILE_BYPASS_EN.
module register_file_mp import regfile_pkg::*; #(
  parameter int DEPTH      = 32,
  parameter int BITS       = 64,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [READ_PORTS*addr_w(DEPTH)-1:0]    readAddr,
  output logic [READ_PORTS*BITS-1:0]             readData,
  output logic [READ_PORTS-1:0]                  readBusy,
  input  logic [addr_w(DEPTH)-1:0]               writeAddr,
  input  logic [BITS-1:0]                        writeData,
  input  logic                                   writeEn,
  input  logic                                   issueEn,
  input  logic [addr_w(DEPTH)-1:0]               issueAddr,
  input  logic                                   clearReq,
  output logic                                   clearBusy,
  output logic                                   clearDone
);

  localparam int AW = addr_w(DEPTH);

  clear_state_t          r_state;
  logic [AW-1:0]         r_idx;
  logic                  r_clear_busy;
  logic                  r_clear_done;
  logic [BITS-1:0]       r_regs [DEPTH];

  logic                  w_idle;
  logic                  w_sweep;
  logic                  w_wr_zero;
  logic                  w_iss_zero;
  logic                  w_wr_ok;
  logic                  w_iss_ok;
  logic                  w_wb_ok;
  logic [READ_PORTS-1:0] w_sb_busy;

  assign w_idle     = (r_state == IDLE);
  assign w_sweep    = (r_state == CLEAR);
  assign w_wr_zero  = (ZERO_REG != 0) && (writeAddr == '0);
  assign w_iss_zero = (ZERO_REG != 0) && (issueAddr == '0);
  // Datapath updates are only accepted while the clear engine is idle.
  assign w_wr_ok    = writeEn && w_idle && !w_wr_zero;
  assign w_wb_ok    = writeEn && w_idle;
  assign w_iss_ok   = issueEn && w_idle && !w_iss_zero;

  // Clear engine: sweep every register once, then a one-cycle DONE before returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_clear_busy <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clearReq) begin
            r_state      <= CLEAR;
            r_clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          // Index wraps back to 0 after the last register, ready for the next sweep.
          r_idx <= r_idx + AW'(1);
          if (r_idx == AW'(DEPTH - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_clear_busy <= 1'b0;
          r_clear_done <= 1'b1;
        end
        default: begin
          r_state      <= IDLE;
          r_clear_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clearBusy = r_clear_busy;
  assign clearDone = r_clear_done;

  // Register storage: sweep writes zero at the current index, otherwise accept writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_sweep) begin
      r_regs[r_idx] <= '0;
    end else if (w_wr_ok) begin
      r_regs[writeAddr] <= writeData;
    end
  end

  regfile_scoreboard #(
    .DEPTH      (DEPTH),
    .READ_PORTS (READ_PORTS),
    .ZERO_REG   (ZERO_REG),
    .AW         (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set_en    (w_iss_ok),
    .i_set_addr  (issueAddr),
    .i_clr_en    (w_wb_ok),
    .i_clr_addr  (writeAddr),
    .i_wipe_en   (w_sweep),
    .i_wipe_addr (r_idx),
    .i_rd_addr   (readAddr),
    .o_busy      (w_sb_busy)
  );

  genvar p;
  generate
    for (p = 0; p < READ_PORTS; p++) begin : g_rd
      logic [AW-1:0]   w_raddr;
      logic [BITS-1:0] w_stored;
      logic            w_hit;

      assign w_raddr  = readAddr[p*AW +: AW];
      // Hardwired zero register reads 0 regardless of storage.
      assign w_stored = ((ZERO_REG != 0) && (w_raddr == '0)) ? '0 : r_regs[w_raddr];

`ifdef REGFILE_BYPASS_EN
      // Forward the in-flight writeback so decode sees it in the same cycle.
      assign w_hit = w_wr_ok && (writeAddr == w_raddr);
`else
      assign w_hit = 1'b0;
`endif

      assign readData[p*BITS +: BITS] = w_hit ? writeData : w_stored;
      assign readBusy[p]              = w_hit ? 1'b0 : w_sb_busy[p];
    end
  endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  localparam int D  = 32;
  localparam int W  = 64;
  localparam int PA = 3;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [PA*AW-1:0] ra_a;
  logic [AW-1:0]   ra_b;
  logic [PA*W-1:0] rd_a;
  logic [W-1:0]    rd_b;
  logic [PA-1:0]   busy_a;
  logic [0:0]      busy_b;
  logic [AW-1:0]   wa, ia;
  logic [W-1:0]    wd;
  logic            we, ie, creq;
  logic            cb_a, cd_a, cb_b, cd_b;

  int checks = 0;
  int errors = 0;

  // Reference model: [0] = zero-register file, [1] = ordinary register 0.
  logic [W-1:0] m_reg  [2][D];
  bit           m_pend [2][D];
  int           m_phase;   // 0 idle, 1 sweeping, 2 finishing
  int           m_k;
  bit           m_done;

  register_file_mp #(.DEPTH(D), .BITS(W), .READ_PORTS(PA), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .readAddr(ra_a), .readData(rd_a), .readBusy(busy_a),
    .writeAddr(wa), .writeData(wd), .writeEn(we), .issueEn(ie), .issueAddr(ia),
    .clearReq(creq), .clearBusy(cb_a), .clearDone(cd_a));

  register_file_mp #(.DEPTH(D), .BITS(W), .READ_PORTS(1), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .readAddr(ra_b), .readData(rd_b), .readBusy(busy_b),
    .writeAddr(wa), .writeData(wd), .writeEn(we), .issueEn(ie), .issueAddr(ia),
    .clearReq(creq), .clearBusy(cb_b), .clearDone(cd_b));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_data(input int inst, input logic [AW-1:0] a);
    bit zr;
    zr = (inst == 0);
`ifdef REGFILE_BYPASS_EN
    if (we && m_phase == 0 && wa == a && !(zr && wa == 0)) return wd;
`endif
    if (zr && a == 0) return '0;
    return m_reg[inst][a];
  endfunction

  function automatic logic exp_busy(input int inst, input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (we && m_phase == 0 && wa == a && !(inst == 0 && wa == 0)) return 1'b0;
`endif
    return m_pend[inst][a];
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++)
      for (int r = 0; r < D; r++) begin
        m_reg[n][r]  = '0;
        m_pend[n][r] = 1'b0;
      end
    m_phase = 0;
    m_k     = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_edge();
    if (m_phase == 0) begin
      m_done = 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (we && !(n == 0 && wa == 0)) m_reg[n][wa] = wd;
        if (we) m_pend[n][wa] = 1'b0;
        if (ie && !(n == 0 && ia == 0)) m_pend[n][ia] = 1'b1;
      end
      if (creq) begin
        m_phase = 1;
        m_k     = 0;
      end
    end else if (m_phase == 1) begin
      m_done = 1'b0;
      for (int n = 0; n < 2; n++) begin
        m_reg[n][m_k]  = '0;
        m_pend[n][m_k] = 1'b0;
      end
      m_k++;
      if (m_k == D) m_phase = 2;
    end else begin
      m_phase = 0;
      m_done  = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    for (int p = 0; p < PA; p++) begin
      chk($sformatf("%s.dataA%0d", tag, p), rd_a[p*W +: W], exp_data(0, ra_a[p*AW +: AW]));
      chk($sformatf("%s.busyA%0d", tag, p), W'(busy_a[p]), W'(exp_busy(0, ra_a[p*AW +: AW])));
    end
    chk({tag, ".dataB"}, rd_b, exp_data(1, ra_b));
    chk({tag, ".busyB"}, W'(busy_b[0]), W'(exp_busy(1, ra_b)));
    chk({tag, ".clrBusyA"}, W'(cb_a), W'(m_phase != 0));
    chk({tag, ".clrDoneA"}, W'(cd_a), W'(m_done));
    chk({tag, ".clrBusyB"}, W'(cb_b), W'(m_phase != 0));
    chk({tag, ".clrDoneB"}, W'(cd_b), W'(m_done));
  endtask

  task automatic tick(input string tag);
    #2 check_all(tag);
    @(posedge clk);
    #1 model_edge();
  endtask

  task automatic set_reads(input int a0, input int a1, input int a2, input int b);
    ra_a = {AW'(a2), AW'(a1), AW'(a0)};
    ra_b = AW'(b);
  endtask

  task automatic rand_reads();
    set_reads($urandom_range(0, D-1), $urandom_range(0, D-1), $urandom_range(0, D-1),
              $urandom_range(0, D-1));
  endtask

  task automatic idle_in();
    we = 1'b0; ie = 1'b0; creq = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int done_e;
    idle_in();
    wa = '0; ia = '0; wd = '0;
    set_reads(0, 0, 0, 0);
    model_reset();

    // Reset state.
    #1 check_all("reset0");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load registers and pending bits, then reset mid-cycle.
    for (int i = 1; i <= 5; i++) begin
      we = 1'b1; wa = AW'(i); wd = {$urandom, $urandom};
      ie = 1'b1; ia = AW'(i + 10);
      set_reads(i, i + 10, 0, i);
      tick("load");
    end
    idle_in();
    set_reads(1, 2, 11, 3);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_mid");
    chk("rst_mid.x1", rd_a[0 +: W], 64'h0);
    chk("rst_mid.busy_x11", W'(busy_a[2]), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero register: write and issue x0.
    we = 1'b1; wa = '0; wd = 64'hDEAD; ie = 1'b1; ia = '0;
    set_reads(0, 0, 0, 0);
    tick("zero_wr");
    idle_in();
    #2;
    chk("zero.dataA", rd_a[0 +: W], 64'h0);
    chk("zero.busyA", W'(busy_a[0]), 64'h0);
    chk("zero.dataB", rd_b, 64'hDEAD);
    tick("zero_rd");

    // Scoreboard on x5.
    ie = 1'b1; ia = 5'd5;
    set_reads(5, 5, 5, 5);
    tick("sb_issue");
    idle_in();
    #2 chk("sb.busy_after_issue", W'(busy_a[0]), 64'h1);
    we = 1'b1; wa = 5'd5; wd = 64'h1234; ie = 1'b1; ia = 5'd5;
    tick("sb_wr_issue");
    idle_in();
    #2;
    chk("sb.busy_same_cycle", W'(busy_a[1]), 64'h1);
    chk("sb.data_same_cycle", rd_a[W +: W], 64'h1234);
    we = 1'b1; wa = 5'd5; wd = 64'h1234;
    tick("sb_wr_only");
    idle_in();
    #2 chk("sb.busy_cleared", W'(busy_a[2]), 64'h0);

    // Clear engine: fill x1..x31 with their index, then sweep.
    for (int i = 1; i < D; i++) begin
      we = 1'b1; wa = AW'(i); wd = W'(i);
      ie = (i % 3 == 0); ia = AW'(i + 1);
      rand_reads();
      tick("fill");
    end
    idle_in();
    creq = 1'b1;
    rand_reads();
    tick("clr_req");
    busy_cnt = cb_a ? 1 : 0;
    done_e   = cd_a ? 0 : -1;
    for (int e = 1; e <= 36; e++) begin
      idle_in();
      if (e == 10) begin
        we = 1'b1; wa = 5'd7; wd = 64'h77; ie = 1'b1; ia = 5'd7;
      end
      if (e == 5) creq = 1'b1;
      rand_reads();
      tick("clr_run");
      if (cb_a) busy_cnt++;
      if (cd_a) done_e = e;
    end
    chk("clr.busy_cycles", W'(busy_cnt), 64'd33);
    chk("clr.done_edge", W'(done_e), 64'd33);
    idle_in();
    for (int a = 0; a < D; a++) begin
      set_reads(a, a, a, a);
      #2;
      chk($sformatf("clr.x%0d", a), rd_a[0 +: W], 64'h0);
      chk($sformatf("clr.busy%0d", a), W'(busy_a[0]), 64'h0);
      tick("post_clr");
    end

    // Bypass on x9.
    we = 1'b1; wa = 5'd9; wd = 64'h1111;
    set_reads(9, 9, 9, 9);
    tick("byp_pre");
    we = 1'b1; wa = 5'd9; wd = 64'hCAFE;
    #2;
    for (int p = 0; p < PA; p++) begin
`ifdef REGFILE_BYPASS_EN
      chk($sformatf("byp.same%0d", p), rd_a[p*W +: W], 64'hCAFE);
`else
      chk($sformatf("byp.same%0d", p), rd_a[p*W +: W], 64'h1111);
`endif
    end
    tick("byp_wr");
    idle_in();
    #2;
    for (int p = 0; p < PA; p++)
      chk($sformatf("byp.next%0d", p), rd_a[p*W +: W], 64'hCAFE);
    tick("byp_next");

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      we   = 1'($urandom_range(0, 1));
      wa   = AW'($urandom_range(0, D-1));
      wd   = {$urandom, $urandom};
      ie   = 1'($urandom_range(0, 1));
      ia   = AW'($urandom_range(0, D-1));
      creq = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        int a;
        a = $urandom_range(0, D-1);
        wa = AW'(a);
        set_reads(a, $urandom_range(0, D-1), a, a);
      end else begin
        rand_reads();
      end
      tick("rand");
    end
    idle_in();
    for (int n = 0; n < 40; n++) tick("drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
